// File: rtl/uart_link_param.sv
// uart_link_param: parametrised full-duplex UART link with internal loopback.
//
// A TX serialiser and an RX deserialiser built on the same bit timing. Each
// bit period is timed by its own down-counter that is reloaded explicitly
// when it reaches terminal count, so there is no free-running baud tick.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   tx_data        word to transmit (captured on acceptance)
//   tx_valid       tx_data valid
//   tx_ready       TX idle, can accept a word
//   tx_busy        frame being shifted out (= !tx_ready)
//   txd            serial out, idles high; held high in loopback
//   rxd            serial in, asynchronous to clk
//   loopback       1 = RX fed from the internal TX stream
//   rx_data        last received word
//   rx_valid       one-cycle pulse, rx_data and flags valid
//   rx_parity_err  parity mismatch, qualified by rx_valid
//   rx_frame_err   a stop bit sampled low, qualified by rx_valid
//
// FSM states (shared encoding for TX and RX):
//   state   | meaning
//   S_IDLE  | TX: ready for a word / RX: waiting for line low
//   S_START | TX: driving start bit / RX: timing to start-bit centre
//   S_DATA  | data bits, LSB first
//   S_PAR   | parity bit (only entered when PARITY != 0)
//   S_STOP  | stop bit(s)
module uart_link_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              txd,
  input  logic              rxd,
  input  logic              loopback,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam bit               PAR_EN    = (PARITY != 0);
  localparam bit               PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_e;

  // TX state
  state_e              tx_state_q, tx_state_d;
  logic [CNT_W-1:0]    tx_cnt_q,   tx_cnt_d;
  logic [BIT_W-1:0]    tx_bit_q,   tx_bit_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic                tx_par_q,   tx_par_d;
  logic                tx_line_q,  tx_line_d;

  // RX state
  logic                rx_sync1_q, rx_sync2_q;
  state_e              rx_state_q, rx_state_d;
  logic [CNT_W-1:0]    rx_cnt_q,   rx_cnt_d;
  logic [BIT_W-1:0]    rx_bit_q,   rx_bit_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic                rx_pacc_q,  rx_pacc_d;
  logic                rx_facc_q,  rx_facc_d;
  logic [DATA_W-1:0]   rx_data_q,  rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_perr_q,  rx_perr_d;
  logic                rx_ferr_q,  rx_ferr_d;

  logic rx_src;
  logic rx_line;
  logic tx_tc;
  logic rx_tc;

  assign rx_src  = loopback ? tx_line_q : rxd;
  assign rx_line = rx_sync2_q;
  assign tx_tc   = (tx_cnt_q == '0);
  assign rx_tc   = (rx_cnt_q == '0);

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pacc_q  <= 1'b0;
      rx_facc_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
      rx_sync1_q <= rx_src;
      rx_sync2_q <= rx_sync1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pacc_q  <= rx_pacc_d;
      rx_facc_q  <= rx_facc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // TX next state. The serial line is registered, so each bit value is
  // computed one step ahead at the terminal count of the previous bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;

    if (tx_state_q != S_IDLE && !tx_tc) begin
      tx_cnt_d = tx_cnt_q - CNT_W'(1);
    end

    unique case (tx_state_q)
      S_IDLE: begin
        tx_line_d = 1'b1;
        if (tx_valid) begin
          tx_state_d = S_START;
          tx_cnt_d   = CNT_FULL;
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_ODD;
          tx_line_d  = 1'b0;
        end
      end
      S_START: begin
        if (tx_tc) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end
      end
      S_DATA: begin
        if (tx_tc) begin
          tx_cnt_d = CNT_FULL;
          if (tx_bit_q == LAST_DATA) begin
            tx_bit_d = '0;
            if (PAR_EN) begin
              tx_state_d = S_PAR;
              tx_line_d  = tx_par_q;
            end else begin
              tx_state_d = S_STOP;
              tx_line_d  = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + BIT_W'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      S_PAR: begin
        if (tx_tc) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = CNT_FULL;
          tx_bit_d   = '0;
          tx_line_d  = 1'b1;
        end
      end
      S_STOP: begin
        if (tx_tc) begin
          tx_cnt_d  = CNT_FULL;
          tx_line_d = 1'b1;
          if (tx_bit_q == LAST_STOP) begin
            tx_state_d = S_IDLE;
            tx_bit_d   = '0;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // RX next state. The first reload is half a bit so that every later
  // terminal count lands on a bit centre.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pacc_d  = rx_pacc_q;
    rx_facc_d  = rx_facc_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = 1'b0;
    rx_ferr_d  = 1'b0;

    if (rx_state_q != S_IDLE && !rx_tc) begin
      rx_cnt_d = rx_cnt_q - CNT_W'(1);
    end

    unique case (rx_state_q)
      S_IDLE: begin
        if (!rx_line) begin
          rx_state_d = S_START;
          rx_cnt_d   = CNT_HALF;
          rx_bit_d   = '0;
          rx_pacc_d  = 1'b0;
          rx_facc_d  = 1'b0;
        end
      end
      S_START: begin
        if (rx_tc) begin
          rx_cnt_d = CNT_FULL;
          // Line back high at start-bit centre: glitch, not a frame.
          rx_state_d = rx_line ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_tc) begin
          rx_cnt_d   = CNT_FULL;
          rx_shift_d = {rx_line, rx_shift_q[DATA_W-1:1]};
          if (rx_bit_q == LAST_DATA) begin
            rx_bit_d   = '0;
            rx_state_d = PAR_EN ? S_PAR : S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (rx_tc) begin
          rx_cnt_d   = CNT_FULL;
          rx_pacc_d  = ((^rx_shift_q) ^ PAR_ODD) != rx_line;
          rx_state_d = S_STOP;
          rx_bit_d   = '0;
        end
      end
      S_STOP: begin
        if (rx_tc) begin
          rx_cnt_d = CNT_FULL;
          if (rx_bit_q == LAST_STOP) begin
            rx_state_d = S_IDLE;
            rx_bit_d   = '0;
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_perr_d  = rx_pacc_q;
            rx_ferr_d  = rx_facc_q | !rx_line;
          end else begin
            rx_bit_d  = rx_bit_q + BIT_W'(1);
            rx_facc_d = rx_facc_q | !rx_line;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tx_ready      = (tx_state_q == S_IDLE);
    tx_busy       = (tx_state_q != S_IDLE);
    txd           = loopback ? 1'b1 : tx_line_q;
    rx_data       = rx_data_q;
    rx_valid      = rx_valid_q;
    rx_parity_err = rx_perr_q;
    rx_frame_err  = rx_ferr_q;
  end

endmodule

// File: tb/tb_uart_link_param.sv
// Bench for uart_link_param: instance a uses default parameters, instance b
// uses even parity with two stop bits.
module tb_uart_link_param;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready_a, tx_ready_b;
  logic       tx_busy_a, tx_busy_b;
  logic       txd_a, txd_b;
  logic       rxd_a, rxd_b;
  logic       loopback_a, loopback_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       rx_perr_a, rx_perr_b;
  logic       rx_ferr_a, rx_ferr_b;

  uart_link_param u_dut_a (
    .clk(clk), .rst(rst_n),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .tx_busy(tx_busy_a), .txd(txd_a), .rxd(rxd_a), .loopback(loopback_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a)
  );

  uart_link_param #(.PARITY(1), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst_n),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .tx_busy(tx_busy_b), .txd(txd_b), .rxd(rxd_b), .loopback(loopback_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // RX monitor: counts pulses and keeps a log of received words and flags
  int         rx_cnt_a = 0, rx_cnt_b = 0;
  logic [7:0] log_a [0:31];
  logic       last_perr_a = 1'b0, last_ferr_a = 1'b0;
  logic [7:0] last_data_b = '0;
  logic       last_perr_b = 1'b0, last_ferr_b = 1'b0;
  int         flag_viol = 0;
  int         txd_viol = 0;

  always @(negedge clk) begin
    if (rx_valid_a) begin
      log_a[rx_cnt_a[4:0]] <= rx_data_a;
      last_perr_a <= rx_perr_a;
      last_ferr_a <= rx_ferr_a;
      rx_cnt_a    <= rx_cnt_a + 1;
    end
    if (rx_valid_b) begin
      last_data_b <= rx_data_b;
      last_perr_b <= rx_perr_b;
      last_ferr_b <= rx_ferr_b;
      rx_cnt_b    <= rx_cnt_b + 1;
    end
    if ((!rx_valid_a && (rx_perr_a || rx_ferr_a)) ||
        (!rx_valid_b && (rx_perr_b || rx_ferr_b)))
      flag_viol <= flag_viol + 1;
    if (loopback_a && txd_a !== 1'b1)
      txd_viol <= txd_viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx(input int sel, input logic v);
    if (sel == 0) rxd_a = v;
    else          rxd_b = v;
  endtask

  // Drives one frame on rxd; instance b frames carry parity and two stops.
  task automatic send_rx(input int sel, input logic [7:0] data,
                         input logic par, input logic stop_last);
    drive_rx(sel, 1'b0);
    tick(C);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, data[i]);
      tick(C);
    end
    if (sel == 1) begin
      drive_rx(sel, par);
      tick(C);
      drive_rx(sel, 1'b1);
      tick(C);
    end
    drive_rx(sel, stop_last);
    tick(C);
    drive_rx(sel, 1'b1);
  endtask

  function automatic logic get_txd(input int sel);
    return (sel == 0) ? txd_a : txd_b;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? tx_ready_a : tx_ready_b;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? tx_busy_a : tx_busy_b;
  endfunction

  // Sends one word and samples txd at every bit centre; exp_bits[i] is the
  // i-th serial bit. Also checks that tx_ready returns after exactly nbits*C.
  task automatic tx_check(input int sel, input logic [7:0] data,
                          input logic [15:0] exp_bits, input int nbits,
                          input string name);
    if (sel == 0) begin tx_data_a = data; tx_valid_a = 1'b1; end
    else          begin tx_data_b = data; tx_valid_b = 1'b1; end
    tick(1);
    if (sel == 0) begin tx_valid_a = 1'b0; tx_data_a = ~data; end
    else          begin tx_valid_b = 1'b0; tx_data_b = ~data; end
    check({name, "_ready_lo"}, 32'(get_ready(sel)), 32'd0);
    check({name, "_busy_hi"}, 32'(get_busy(sel)), 32'd1);
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      check($sformatf("%s_bit%0d", name, i), 32'(get_txd(sel)), 32'(exp_bits[i]));
      if (i < nbits - 1) tick(C);
    end
    tick(7);
    check({name, "_ready_end_lo"}, 32'(get_ready(sel)), 32'd0);
    tick(1);
    check({name, "_ready_end_hi"}, 32'(get_ready(sel)), 32'd1);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    int lowc;
    logic [7:0] got;

    //        sel  data   par   stop  exp    perr  ferr
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[2] = '{0, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[5] = '{1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};

    rst_n = 1'b0;
    tx_data_a = '0; tx_valid_a = 1'b0; rxd_a = 1'b1; loopback_a = 1'b0;
    tx_data_b = '0; tx_valid_b = 1'b0; rxd_b = 1'b1; loopback_b = 1'b0;
    tick(3);
    check("rst_txd", 32'(txd_a), 32'd1);
    check("rst_ready", 32'(tx_ready_a), 32'd1);
    check("rst_busy", 32'(tx_busy_a), 32'd0);
    check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    check("rst_rx_data", 32'(rx_data_a), 32'd0);
    check("rst_flags", 32'({rx_perr_a, rx_ferr_a}), 32'd0);
    rst_n = 1'b1;
    tick(3);

    // Loopback, back-to-back words with tx_valid held
    loopback_a = 1'b1;
    tick(2);
    prev = rx_cnt_a;
    tx_data_a = 8'h0C; tx_valid_a = 1'b1;
    tick(1);
    tx_data_a = 8'h5A;
    lowc = 0;
    while (!tx_ready_a && lowc < 400) begin lowc++; tick(1); end
    check("lb_ready_low1", 32'(lowc), 32'd160);
    tick(1);
    check("lb_no_gap", 32'(tx_ready_a), 32'd0);
    tx_valid_a = 1'b0;
    lowc = 0;
    while (!tx_ready_a && lowc < 400) begin lowc++; tick(1); end
    check("lb_ready_low2", 32'(lowc), 32'd160);
    tick(30);
    check("lb_rx_count", 32'(rx_cnt_a - prev), 32'd2);
    got = log_a[prev[4:0]];
    check("lb_rx_data0", 32'(got), 32'h0C);
    got = log_a[5'(prev + 1)];
    check("lb_rx_data1", 32'(got), 32'h5A);
    check("lb_flags", 32'({last_perr_a, last_ferr_a}), 32'd0);
    check("lb_txd_high", 32'(txd_viol), 32'd0);
    loopback_a = 1'b0;
    tick(4);

    // TX serial format, default parameters: 0x3C -> 0,0,0,1,1,1,1,0,0,1
    tx_check(0, 8'h3C, 16'h0278, 10, "tx3c");
    tick(4);

    // RX vector table
    for (int i = 0; i < 7; i++) begin
      prev = (vecs[i].sel == 0) ? rx_cnt_a : rx_cnt_b;
      send_rx(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].stop);
      tick(8);
      if (vecs[i].sel == 0) begin
        check($sformatf("v%0d_pulses", i), 32'(rx_cnt_a - prev), 32'd1);
        got = log_a[prev[4:0]];
        check($sformatf("v%0d_data", i), 32'(got), 32'(vecs[i].exp_data));
        check($sformatf("v%0d_perr", i), 32'(last_perr_a), 32'(vecs[i].exp_perr));
        check($sformatf("v%0d_ferr", i), 32'(last_ferr_a), 32'(vecs[i].exp_ferr));
      end else begin
        check($sformatf("v%0d_pulses", i), 32'(rx_cnt_b - prev), 32'd1);
        check($sformatf("v%0d_data", i), 32'(last_data_b), 32'(vecs[i].exp_data));
        check($sformatf("v%0d_perr", i), 32'(last_perr_b), 32'(vecs[i].exp_perr));
        check($sformatf("v%0d_ferr", i), 32'(last_ferr_b), 32'(vecs[i].exp_ferr));
      end
    end

    // Even parity, two stops: 0x07 -> 0,1,1,1,0,0,0,0,0,1,1,1
    tx_check(1, 8'h07, 16'h0E0E, 12, "tx07p");
    tick(4);

    // False start: 4-cycle low glitch, then a real frame
    prev = rx_cnt_a;
    rxd_a = 1'b0;
    tick(4);
    rxd_a = 1'b1;
    tick(40);
    check("glitch_no_valid", 32'(rx_cnt_a - prev), 32'd0);
    send_rx(0, 8'h33, 1'b0, 1'b1);
    tick(8);
    check("glitch_next_cnt", 32'(rx_cnt_a - prev), 32'd1);
    got = log_a[prev[4:0]];
    check("glitch_next_data", 32'(got), 32'h33);

    // Reset in the middle of a TX frame (data bit 3 of 0x00)
    tx_data_a = 8'h00; tx_valid_a = 1'b1;
    tick(1);
    tx_valid_a = 1'b0;
    tick(8 + 4 * C);
    check("rst_tx_pre_txd", 32'(txd_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_async_txd", 32'(txd_a), 32'd1);
    check("rst_tx_async_ready", 32'(tx_ready_a), 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rst_tx_ready_after", 32'(tx_ready_a), 32'd1);
    tick(100);
    check("rst_tx_txd_idle", 32'(txd_a), 32'd1);

    // Reset in the middle of an RX frame (data bit 3 of 0x00)
    prev = rx_cnt_a;
    rxd_a = 1'b0;
    tick(C + 3 * C + C / 2);
    rst_n = 1'b0;
    rxd_a = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(200);
    check("rst_rx_no_valid", 32'(rx_cnt_a - prev), 32'd0);

    // Fresh loopback transfer after reset
    loopback_a = 1'b1;
    tick(2);
    prev = rx_cnt_a;
    tx_data_a = 8'hFF; tx_valid_a = 1'b1;
    tick(1);
    tx_valid_a = 1'b0;
    tick(200);
    check("post_rst_cnt", 32'(rx_cnt_a - prev), 32'd1);
    got = log_a[prev[4:0]];
    check("post_rst_data", 32'(got), 32'hFF);
    check("post_rst_flags", 32'({last_perr_a, last_ferr_a}), 32'd0);
    loopback_a = 1'b0;
    tick(4);

    check("flags_only_with_valid", 32'(flag_viol), 32'd0);
    check("loopback_txd_high", 32'(txd_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_link_param.md
Name: uart_link_param

Overview:
- Parametrised full-duplex UART link: serialiser (TX) and deserialiser (RX) sharing one baud generator definition, with an internal loopback mode.
- Successor to the fixed 8-bit top-level UART. Adds configurable data width, parity, stop bits and bit period, a valid/ready TX handshake, and RX error flags.
- Sits between a byte-stream client and the off-chip serial pins.

Parameters:
DATA_W, 8, data bits per frame (5..9), sent LSB first
CLKS_PER_BIT, 16, clk cycles per serial bit (even, >=4)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  TX can accept a word
tx_busy  output  1  frame currently being shifted out
txd  output  1  serial out, idles high
rxd  input  1  serial in, asynchronous to clk
loopback  input  1  1 = RX fed from internal TX stream, txd held high
rx_data  output  DATA_W  last received word
rx_valid  output  1  one-cycle pulse, rx_data/flags valid
rx_parity_err  output  1  parity mismatch, valid with rx_valid
rx_frame_err  output  1  a stop bit sampled 0, valid with rx_valid

Behaviour:
- Frame length F = 1 + DATA_W + (PARITY != 0) + STOP_BITS bits. Each bit lasts exactly CLKS_PER_BIT (C) cycles.
- Reset (rst = 0) values: txd = 1, tx_ready = 1, tx_busy = 0, rx_data = 0, rx_valid = 0, both error flags = 0, synchroniser flops = 1, both FSMs in IDLE.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY = 0) -> STOP -> IDLE.
  - tx_ready = 1 only in IDLE; tx_busy = !tx_ready.
  - Transfer occurs on the edge where tx_valid & tx_ready. tx_data is captured into a shift register; later changes to tx_data have no effect.
  - Serial line goes low on the edge after acceptance (edge k+1). Bits follow LSB first.
  - Parity bit: even = XOR of data bits; odd = its inverse. Stop bit(s) = 1.
  - tx_ready reasserts at edge k+1+F*C. If tx_valid is already high, the next word is accepted on that same cycle, so back-to-back frames have no idle gap.
- Loopback:
  - loopback = 1: txd forced to 1 and the RX input is the internal TX serial stream; rxd is ignored.
  - loopback = 0: TX stream drives txd and RX samples rxd.
  - loopback may change only while both FSMs are IDLE. A mid-frame change may corrupt that frame but both FSMs must be back in IDLE within one frame time.
- RX input: passes a 2-flop synchroniser (reset to 1) before any logic.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - IDLE: wait for synchronised line = 0.
  - START: count C/2 cycles, then re-sample. If the line is 1, it is a false start: return to IDLE with no rx_valid. Otherwise sample every C cycles (bit centres).
  - rx_parity_err = computed parity != received parity bit; always 0 when PARITY = 0.
  - rx_frame_err = any stop-bit sample is 0.
  - At the centre of the last stop bit: rx_data loads the received word (loaded even on error), rx_valid pulses high for one cycle with both flags valid in that cycle, and the FSM returns to IDLE immediately so the next start edge can be caught.
  - Error flags are 0 whenever rx_valid = 0.
  - Latency: rx_valid at synchronised start-edge detect + C/2 + (F-1)*C cycles.
- A line held low at the stop-bit centre gives rx_frame_err = 1. RX then waits in IDLE; a still-low line is treated as a new start and is subject to false-start rejection.
- Reset mid-operation: all state returns to the reset values asynchronously; txd returns high immediately; no rx_valid for the partial frame.
- All counters are sized $clog2(C) and wrap only by explicit reload; there is no free-running baud tick.

Test Plan:
1. Defaults, loopback = 1, tx_valid held with 0x0C then 0x5A -> txd stays 1; tx_ready low for exactly 160 cycles per word with no gap between frames; two rx_valid pulses, rx_data = 0x0C then 0x5A; flags 0.
2. loopback = 0, bench drives rxd with frame 0xA5 at C = 16 -> one rx_valid, rx_data = 0xA5, flags 0. txd of a sent 0x3C checked bit by bit: 0, 0,0,1,1,1,1,0,0, 1.
3. PARITY = 1, STOP_BITS = 2, send 0x07 -> parity bit 1 on txd, 12-bit frame. Bench frame 0x07 with parity 0 -> rx_data = 0x07, rx_parity_err = 1 with rx_valid.
4. Bench frame 0x81 with stop bit driven 0 -> rx_valid with rx_frame_err = 1, rx_data = 0x81. Then line released high; next frame 0x11 is received cleanly.
5. rxd low pulse of 4 cycles (< C/2) -> no rx_valid, RX back in IDLE; the following valid frame 0x33 is received.
6. rst asserted at bit 3 of a TX frame and of an RX frame -> txd = 1 asynchronously, no rx_valid. After release tx_ready = 1 and a fresh 0xFF loopback transfer completes correctly.
